// File: rtl/blake256.sv
// BLAKE-256 (14-round) final-block compression pipeline: one nonce per clock, h7' out 31 cycles later.
// Defining BLAKE256_FULL_DIGEST_EN adds a digest[255:0] port carrying h0'..h7'.
module blake256 (
    input  logic         clk,
    input  logic         reset,
    input  logic         new_block,
    input  logic [255:0] midstate,
    input  logic [95:0]  data,
    input  logic [31:0]  nonce,
    output logic         hash_ready,
`ifdef BLAKE256_FULL_DIGEST_EN
    output logic [255:0] digest,
`endif
    output logic [31:0]  hash
);
    localparam int ROUNDS  = 14;
    localparam int LATENCY = 31;
    localparam int HALF    = 2 * ROUNDS;
    localparam logic [31:0] T0 = 32'h0000_05A0;
    localparam logic [31:0] T1 = 32'h0000_0000;
    localparam logic [511:0] C_ALL = {
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917
    };

`ifdef BLAKE256_FULL_DIGEST_EN
    localparam int OUT_W = 256;
`else
    localparam int OUT_W = 32;
`endif

    function automatic logic [31:0] c_word(input logic [3:0] i);
        return C_ALL[(15 - i) * 32 +: 32];
    endfunction

    // Each row holds sigma[row][0..15] with element 0 in the top nibble.
    function automatic logic [3:0] sigma(input int row, input logic [3:0] idx);
        logic [63:0] r;
        case (row)
            0:       r = 64'h0123456789ABCDEF;
            1:       r = 64'hEA489FD61C02B753;
            2:       r = 64'hB8C052FDAE367194;
            3:       r = 64'h7931DCBE265A40F8;
            4:       r = 64'h905724AFE1BC683D;
            5:       r = 64'h2C6A0B834D75FE19;
            6:       r = 64'hC51FED4A0763928B;
            7:       r = 64'hDB7EC13950F4862A;
            8:       r = 64'h6FE9B308C2D714A5;
            default: r = 64'hA2847615FB9E3CD0;
        endcase
        return r[(15 - idx) * 4 +: 4];
    endfunction

    function automatic logic [31:0] ror16(input logic [31:0] x);
        return {x[15:0], x[31:16]};
    endfunction
    function automatic logic [31:0] ror12(input logic [31:0] x);
        return {x[11:0], x[31:12]};
    endfunction
    function automatic logic [31:0] ror8(input logic [31:0] x);
        return {x[7:0], x[31:8]};
    endfunction
    function automatic logic [31:0] ror7(input logic [31:0] x);
        return {x[6:0], x[31:7]};
    endfunction

    // Only m3 (the nonce) varies per slot; everything else is the fixed tail of a 180-byte header.
    function automatic logic [511:0] build_msg(input logic [95:0] d, input logic [31:0] n);
        logic [511:0] m;
        m = '0;
        m[0 +: 32]       = d[95:64];
        m[32 +: 32]      = d[63:32];
        m[64 +: 32]      = d[31:0];
        m[96 +: 32]      = n;
        m[13 * 32 +: 32] = 32'h8000_0001;
        m[15 * 32 +: 32] = 32'h0000_05A0;
        return m;
    endfunction

    // One half-round: the four column G's, or the four diagonal G's when diag is set.
    function automatic logic [511:0] half_round(input logic [511:0] v_in, input logic [511:0] m,
                                                input int rnd, input logic diag);
        logic [31:0]  v [16];
        logic [511:0] v_out;
        logic [3:0]   ai, bi, ci, di, gsel, mx, my;
        for (int i = 0; i < 16; i++) v[i] = v_in[i * 32 +: 32];
        for (int g = 0; g < 4; g++) begin
            ai = 4'(g);
            if (diag) begin
                bi   = 4'(4 + (g + 1) % 4);
                ci   = 4'(8 + (g + 2) % 4);
                di   = 4'(12 + (g + 3) % 4);
                gsel = 4'(g + 4);
            end else begin
                bi   = 4'(g + 4);
                ci   = 4'(g + 8);
                di   = 4'(g + 12);
                gsel = 4'(g);
            end
            mx = sigma(rnd % 10, {gsel[2:0], 1'b0});
            my = sigma(rnd % 10, {gsel[2:0], 1'b1});
            v[ai] = v[ai] + v[bi] + (m[32 * mx +: 32] ^ c_word(my));
            v[di] = ror16(v[di] ^ v[ai]);
            v[ci] = v[ci] + v[di];
            v[bi] = ror12(v[bi] ^ v[ci]);
            v[ai] = v[ai] + v[bi] + (m[32 * my +: 32] ^ c_word(mx));
            v[di] = ror8(v[di] ^ v[ai]);
            v[ci] = v[ci] + v[di];
            v[bi] = ror7(v[bi] ^ v[ci]);
        end
        v_out = '0;
        for (int i = 0; i < 16; i++) v_out[i * 32 +: 32] = v[i];
        return v_out;
    endfunction

    logic [255:0]     mid_q;
    logic [95:0]      data_q;
    logic             running_q;
    logic [LATENCY-1:0] valid_q;
    logic [255:0]     mid_sel;
    logic [511:0]     v_init_d;
    logic [511:0]     v_d [1:HALF];
    logic [511:0]     v_q [0:HALF];
    logic [31:0]      nonce_q [0:HALF-1];
    logic [OUT_W-1:0] fin_d;
    logic [OUT_W-1:0] fin_q;
    logic [OUT_W-1:0] hash_q;

    // The first slot of a new stream must already see the incoming midstate.
    always_comb begin
        mid_sel  = new_block ? midstate : mid_q;
        v_init_d = '0;
        for (int i = 0; i < 8; i++) v_init_d[i * 32 +: 32] = mid_sel[(7 - i) * 32 +: 32];
        for (int i = 0; i < 4; i++) v_init_d[(8 + i) * 32 +: 32] = c_word(4'(i));
        v_init_d[12 * 32 +: 32] = c_word(4'd4) ^ T0;
        v_init_d[13 * 32 +: 32] = c_word(4'd5) ^ T0;
        v_init_d[14 * 32 +: 32] = c_word(4'd6) ^ T1;
        v_init_d[15 * 32 +: 32] = c_word(4'd7) ^ T1;
    end

    genvar gi;
    generate
        for (gi = 1; gi <= HALF; gi++) begin : g_stage
            assign v_d[gi] = half_round(v_q[gi-1], build_msg(data_q, nonce_q[gi-1]),
                                        (gi - 1) / 2, (gi % 2) == 0);
        end
        // Word gi of the output is h(7-gi)'; the default build keeps only h7'.
        for (gi = 0; gi < OUT_W / 32; gi++) begin : g_final
            assign fin_d[gi * 32 +: 32] = mid_q[gi * 32 +: 32]
                                        ^ v_q[HALF][(7 - gi) * 32 +: 32]
                                        ^ v_q[HALF][(15 - gi) * 32 +: 32];
        end
    endgenerate

    always_ff @(posedge clk) begin
        v_q[0]     <= v_init_d;
        nonce_q[0] <= nonce;
        for (int k = 1; k <= HALF; k++) v_q[k] <= v_d[k];
        for (int k = 1; k < HALF; k++) nonce_q[k] <= nonce_q[k-1];
        fin_q <= fin_d;
    end

    // valid_q[k] tags pipeline stage k; a new block flushes every in-flight tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_q <= 1'b0;
            valid_q   <= '0;
            mid_q     <= '0;
            data_q    <= '0;
            hash_q    <= '0;
        end else if (new_block) begin
            running_q <= 1'b1;
            valid_q   <= {{(LATENCY-1){1'b0}}, 1'b1};
            mid_q     <= midstate;
            data_q    <= data;
        end else begin
            valid_q <= {valid_q[LATENCY-2:0], running_q};
            if (valid_q[LATENCY-2]) hash_q <= fin_q;
        end
    end

    assign hash_ready = valid_q[LATENCY-1];
    assign hash       = hash_q[31:0];
`ifdef BLAKE256_FULL_DIGEST_EN
    assign digest     = hash_q;
`endif

endmodule

// File: tb/tb_blake256.sv
// Self-checking bench for blake256: a reference BLAKE-256 model fills a scoreboard that is
// popped as results leave the 31-cycle pipeline.
module tb_blake256;
    localparam int LAT = 31;

    logic         clk = 1'b0;
    logic         reset;
    logic         new_block;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic [31:0]  nonce;
    logic         hash_ready;
    logic [31:0]  hash;
`ifdef BLAKE256_FULL_DIGEST_EN
    logic [255:0] digest;
`endif

    always #5 clk = ~clk;

    blake256 dut (
        .clk        (clk),
        .reset      (reset),
        .new_block  (new_block),
        .midstate   (midstate),
        .data       (data),
        .nonce      (nonce),
        .hash_ready (hash_ready),
`ifdef BLAKE256_FULL_DIGEST_EN
        .digest     (digest),
`endif
        .hash       (hash)
    );

    localparam logic [31:0] CST [16] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344,
        32'hA4093822, 32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89,
        32'h452821E6, 32'h38D01377, 32'hBE5466CF, 32'h34E90C6C,
        32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5, 32'hB5470917};
    localparam int SIG [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}};
    localparam int GIX [8][4] = '{
        '{0, 4,  8, 12}, '{1, 5,  9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
        '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7,  8, 13}, '{3, 4,  9, 14}};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Plain software BLAKE-256 compression of the final 180-byte-header block.
    function automatic logic [255:0] ref_digest(input logic [255:0] h, input logic [95:0] d,
                                                input logic [31:0] n);
        logic [31:0]  m [16];
        logic [31:0]  v [16];
        logic [255:0] r;
        int a, b, c, e, x, y;
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[0] = d[95:64]; m[1] = d[63:32]; m[2] = d[31:0]; m[3] = n;
        m[13] = 32'h80000001; m[15] = 32'h000005A0;
        for (int i = 0; i < 8; i++) begin
            v[i]     = h[255 - 32 * i -: 32];
            v[i + 8] = CST[i];
        end
        v[12] = v[12] ^ 32'h5A0;
        v[13] = v[13] ^ 32'h5A0;
        for (int rnd = 0; rnd < 14; rnd++) begin
            for (int g = 0; g < 8; g++) begin
                a = GIX[g][0]; b = GIX[g][1]; c = GIX[g][2]; e = GIX[g][3];
                x = SIG[rnd % 10][2 * g]; y = SIG[rnd % 10][2 * g + 1];
                v[a] = v[a] + v[b] + (m[x] ^ CST[y]);
                v[e] = rotr(v[e] ^ v[a], 16);
                v[c] = v[c] + v[e];
                v[b] = rotr(v[b] ^ v[c], 12);
                v[a] = v[a] + v[b] + (m[y] ^ CST[x]);
                v[e] = rotr(v[e] ^ v[a], 8);
                v[c] = v[c] + v[e];
                v[b] = rotr(v[b] ^ v[c], 7);
            end
        end
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = h[255 - 32 * i -: 32] ^ v[i] ^ v[i + 8];
        return r;
    endfunction

    typedef struct packed {
        logic         valid;
        logic [31:0]  nonce;
        logic [255:0] dig;
    } exp_t;

    exp_t         sb [$];
    int           checks = 0;
    int           passed = 0;
    int           fails  = 0;
    int           cycle  = 0;
    logic         model_running = 1'b0;
    logic [255:0] model_mid = '0;
    logic [95:0]  model_data = '0;
    logic [255:0] model_out = '0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s @cycle %0d observed=%h expected=%h", tag, cycle, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, push its expected result, then compare what leaves the pipe.
    task automatic step(input logic rst, input logic nb, input logic [255:0] ms,
                        input logic [95:0] dt, input logic [31:0] n);
        exp_t         e;
        exp_t         o;
        logic [255:0] use_mid;
        logic [95:0]  use_data;
        logic         exp_ready;
        reset = rst; new_block = nb; midstate = ms; data = dt; nonce = n;
        use_mid  = nb ? ms : model_mid;
        use_data = nb ? dt : model_data;
        if (rst) begin
            foreach (sb[i]) sb[i].valid = 1'b0;
            model_running = 1'b0; model_mid = '0; model_data = '0; model_out = '0;
        end else if (nb) begin
            foreach (sb[i]) sb[i].valid = 1'b0;
            model_running = 1'b1; model_mid = ms; model_data = dt;
        end
        e.valid = !rst && model_running;
        e.nonce = n;
        e.dig   = ref_digest(use_mid, use_data, n);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        exp_ready = 1'b0;
        if (sb.size() == LAT) begin
            o = sb.pop_front();
            exp_ready = o.valid;
            if (o.valid) begin
                model_out = o.dig;
                $display("tx cycle=%0d nonce=%h hash=%h", cycle, o.nonce, hash);
            end
        end
        check("hash_ready", {255'h0, hash_ready}, {255'h0, exp_ready});
        check("hash", {224'h0, hash}, {224'h0, model_out[31:0]});
`ifdef BLAKE256_FULL_DIGEST_EN
        check("digest", digest, model_out);
`endif
    endtask

    logic [255:0] mid_a, mid_b;
    logic [95:0]  data_a, data_b;

    initial begin
        mid_a  = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;
        mid_b  = 256'hDEADBEEF_01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_C0FFEE00;
        data_a = 96'h11223344_55667788_99AABBCC;
        data_b = 96'hA5A5A5A5_5A5A5A5A_00000001;

        // reset state
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 32'h0);

        // all-zero block, nonce counting up from 0
        step(1'b0, 1'b1, '0, '0, 32'h0);
        for (int i = 1; i <= 45; i++) step(1'b0, 1'b0, '0, '0, 32'(i));

        // second new_block ten cycles into a stream
        step(1'b0, 1'b1, mid_a, data_a, 32'h1000);
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, mid_a, data_a, 32'h1000 + 32'(i));
        step(1'b0, 1'b1, mid_b, data_b, 32'h2000);
        for (int i = 1; i <= 45; i++) step(1'b0, 1'b0, mid_a, data_a, 32'h2000 + 32'(i));

        // reset coincident with new_block: reset wins
        step(1'b1, 1'b1, mid_a, data_a, 32'h3000);
        for (int i = 1; i <= 40; i++) step(1'b0, 1'b0, mid_b, data_b, 32'h3000 + 32'(i));

        // nonce wrap across 0xFFFFFFFF
        step(1'b0, 1'b1, mid_b, data_a, 32'hFFFF_FFF0);
        for (int i = 1; i <= 45; i++) step(1'b0, 1'b0, mid_b, data_a, 32'hFFFF_FFF0 + 32'(i));

        // reset mid-stream
        for (int i = 0; i < 5; i++) step(i == 0, 1'b0, '0, '0, 32'(i));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
